sb_1m4s: RTL and testbench

//  Simple-bus address decoder/router, downstream of the 2-master arbiter's slave port: one sb master, four sb slaves.

---
 rtl/sb_pkg.sv | 28 ++
 rtl/sb_addr_dec.sv | 28 ++
 rtl/sb_1m4s.sv | 165 ++++++++++++++++
 tb/tb_sb_1m4s.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared constants and helpers for the simple-bus 1-master/4-slave router.
package sb_pkg;

  localparam int SB_NSLV  = 4;
  localparam int SB_SEL_W = 3;

  typedef logic [SB_SEL_W-1:0] sb_sel_t;

  // Select code for the internal error slave (one past the last real slave)
  localparam sb_sel_t SB_ERR_SEL = 3'd4;

  // Default address windows
  localparam logic [31:0] SB_S0_BASE = 32'h0000_0000;
  localparam logic [31:0] SB_S0_MASK = 32'hFFFF_0000;
  localparam logic [31:0] SB_S1_BASE = 32'h2000_0000;
  localparam logic [31:0] SB_S1_MASK = 32'hFFFF_0000;
  localparam logic [31:0] SB_S2_BASE = 32'h4000_0000;
  localparam logic [31:0] SB_S2_MASK = 32'hFFFF_F000;
  localparam logic [31:0] SB_S3_BASE = 32'h4000_1000;
  localparam logic [31:0] SB_S3_MASK = 32'hFFFF_F000;

  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/sb_addr_dec.sv
// Combinational address decoder: maps an address to a slave select code,
// lowest-index window wins on overlap, no hit selects the error slave.
module sb_addr_dec
  import sb_pkg::*;
#(
  parameter logic [31:0] S0_BASE = SB_S0_BASE,
  parameter logic [31:0] S0_MASK = SB_S0_MASK,
  parameter logic [31:0] S1_BASE = SB_S1_BASE,
  parameter logic [31:0] S1_MASK = SB_S1_MASK,
  parameter logic [31:0] S2_BASE = SB_S2_BASE,
  parameter logic [31:0] S2_MASK = SB_S2_MASK,
  parameter logic [31:0] S3_BASE = SB_S3_BASE,
  parameter logic [31:0] S3_MASK = SB_S3_MASK
) (
  input  logic [31:0] addr,
  output sb_sel_t     sel
);

  // Priority decode, slave 0 first
  always_comb begin
    if (win_hit(addr, S0_BASE, S0_MASK))      sel = 3'd0;
    else if (win_hit(addr, S1_BASE, S1_MASK)) sel = 3'd1;
    else if (win_hit(addr, S2_BASE, S2_MASK)) sel = 3'd2;
    else if (win_hit(addr, S3_BASE, S3_MASK)) sel = 3'd3;
    else                                      sel = SB_ERR_SEL;
  end

endmodule

// File: rtl/sb_1m4s.sv
// Simple-bus router: one master, four slaves plus an internal error slave.
// Read and write paths are independent, each with one outstanding transaction.
module sb_1m4s
  import sb_pkg::*;
#(
  parameter logic [31:0] S0_BASE   = SB_S0_BASE,
  parameter logic [31:0] S0_MASK   = SB_S0_MASK,
  parameter logic [31:0] S1_BASE   = SB_S1_BASE,
  parameter logic [31:0] S1_MASK   = SB_S1_MASK,
  parameter logic [31:0] S2_BASE   = SB_S2_BASE,
  parameter logic [31:0] S2_MASK   = SB_S2_MASK,
  parameter logic [31:0] S3_BASE   = SB_S3_BASE,
  parameter logic [31:0] S3_MASK   = SB_S3_MASK,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sb_arvalid_m,
  output logic         sb_arready_m,
  input  logic [31:0]  sb_araddr_m,
  output logic         sb_rvalid_m,
  input  logic         sb_rready_m,
  output logic [31:0]  sb_rdata_m,
  input  logic         sb_wvalid_m,
  output logic         sb_wready_m,
  input  logic [31:0]  sb_waddr_m,
  input  logic [31:0]  sb_wdata_m,
  input  logic [3:0]   sb_wstrb_m,
  output logic         sb_bvalid_m,
  input  logic         sb_bready_m,
  output logic         sb_bresp_m,
  output logic [3:0]   sb_arvalid_s,
  input  logic [3:0]   sb_arready_s,
  output logic [31:0]  sb_araddr_s,
  input  logic [3:0]   sb_rvalid_s,
  output logic [3:0]   sb_rready_s,
  input  logic [127:0] sb_rdata_s,
  output logic [3:0]   sb_wvalid_s,
  input  logic [3:0]   sb_wready_s,
  output logic [31:0]  sb_waddr_s,
  output logic [31:0]  sb_wdata_s,
  output logic [3:0]   sb_wstrb_s,
  input  logic [3:0]   sb_bvalid_s,
  output logic [3:0]   sb_bready_s,
  input  logic [3:0]   sb_bresp_s,
  output logic         dec_err
);

  sb_sel_t sel_r, sel_w;
  sb_sel_t rsel, wsel;
  logic    rflag, wflag;
  logic    r_ok, ar_ok, gate_r;
  logic    b_ok, w_ok, gate_w;

  sb_addr_dec #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE), .S2_MASK(S2_MASK), .S3_BASE(S3_BASE), .S3_MASK(S3_MASK)
  ) u_dec_r (
    .addr(sb_araddr_m),
    .sel (sel_r)
  );

  sb_addr_dec #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK), .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE), .S2_MASK(S2_MASK), .S3_BASE(S3_BASE), .S3_MASK(S3_MASK)
  ) u_dec_w (
    .addr(sb_waddr_m),
    .sel (sel_w)
  );

  // Request payloads are broadcast; only the valid is steered
  assign sb_araddr_s = sb_araddr_m;
  assign sb_waddr_s  = sb_waddr_m;
  assign sb_wdata_s  = sb_wdata_m;
  assign sb_wstrb_s  = sb_wstrb_m;

  // A new request may go out when idle or in the cycle the previous response completes
  assign r_ok   = sb_rvalid_m & sb_rready_m;
  assign gate_r = ~rflag | r_ok;
  assign ar_ok  = sb_arvalid_m & sb_arready_m;
  assign b_ok   = sb_bvalid_m & sb_bready_m;
  assign gate_w = ~wflag | b_ok;
  assign w_ok   = sb_wvalid_m & sb_wready_m;

  // R return: the error slave answers as soon as the tracker is armed
  always_comb begin
    sb_rready_s = '0;
    if (rsel == SB_ERR_SEL) begin
      sb_rvalid_m = rflag;
      sb_rdata_m  = ERR_RDATA;
    end else begin
      sb_rvalid_m               = rflag & sb_rvalid_s[rsel[1:0]];
      sb_rdata_m                = sb_rdata_s[{rsel[1:0], 5'd0} +: 32];
      sb_rready_s[rsel[1:0]]    = rflag & sb_rready_m;
    end
  end

  // AR steering to the decoded slave; the error slave is always ready
  always_comb begin
    sb_arvalid_s = '0;
    if (sel_r == SB_ERR_SEL) begin
      sb_arready_m = gate_r;
    end else begin
      sb_arready_m              = gate_r & sb_arready_s[sel_r[1:0]];
      sb_arvalid_s[sel_r[1:0]]  = sb_arvalid_m & gate_r;
    end
  end

  // B return, mirror of the R path; the error slave reports an error response
  always_comb begin
    sb_bready_s = '0;
    if (wsel == SB_ERR_SEL) begin
      sb_bvalid_m = wflag;
      sb_bresp_m  = 1'b1;
    end else begin
      sb_bvalid_m               = wflag & sb_bvalid_s[wsel[1:0]];
      sb_bresp_m                = sb_bresp_s[wsel[1:0]];
      sb_bready_s[wsel[1:0]]    = wflag & sb_bready_m;
    end
  end

  // W steering, mirror of the AR path
  always_comb begin
    sb_wvalid_s = '0;
    if (sel_w == SB_ERR_SEL) begin
      sb_wready_m = gate_w;
    end else begin
      sb_wready_m               = gate_w & sb_wready_s[sel_w[1:0]];
      sb_wvalid_s[sel_w[1:0]]   = sb_wvalid_m & gate_w;
    end
  end

  // Read tracker: arm on AR acceptance, disarm when R completes with no new AR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rflag <= 1'b0;
      rsel  <= '0;
    end else if (ar_ok) begin
      rflag <= 1'b1;
      rsel  <= sel_r;
    end else if (r_ok) begin
      rflag <= 1'b0;
    end
  end

  // Write tracker: arm on W acceptance, disarm when B completes with no new W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wflag <= 1'b0;
      wsel  <= '0;
    end else if (w_ok) begin
      wflag <= 1'b1;
      wsel  <= sel_w;
    end else if (b_ok) begin
      wflag <= 1'b0;
    end
  end

  // One-cycle pulse after any request accepted by the error slave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_err <= 1'b0;
    else        dec_err <= (ar_ok & (sel_r == SB_ERR_SEL)) | (w_ok & (sel_w == SB_ERR_SEL));
  end

endmodule

// File: tb/tb_sb_1m4s.sv
// Randomized scoreboard bench for sb_1m4s with behavioural slave models.
module tb_sb_1m4s;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sb_arvalid_m, sb_arready_m;
  logic [31:0]  sb_araddr_m;
  logic         sb_rvalid_m, sb_rready_m;
  logic [31:0]  sb_rdata_m;
  logic         sb_wvalid_m, sb_wready_m;
  logic [31:0]  sb_waddr_m, sb_wdata_m;
  logic [3:0]   sb_wstrb_m;
  logic         sb_bvalid_m, sb_bready_m, sb_bresp_m;
  logic [3:0]   sb_arvalid_s, sb_arready_s;
  logic [31:0]  sb_araddr_s;
  logic [3:0]   sb_rvalid_s, sb_rready_s;
  logic [127:0] sb_rdata_s;
  logic [3:0]   sb_wvalid_s, sb_wready_s;
  logic [31:0]  sb_waddr_s, sb_wdata_s;
  logic [3:0]   sb_wstrb_s;
  logic [3:0]   sb_bvalid_s, sb_bready_s, sb_bresp_s;
  logic         dec_err;

  always #5 clk = ~clk;

  sb_1m4s dut (
    .clk(clk), .rst_n(rst_n),
    .sb_arvalid_m(sb_arvalid_m), .sb_arready_m(sb_arready_m), .sb_araddr_m(sb_araddr_m),
    .sb_rvalid_m(sb_rvalid_m), .sb_rready_m(sb_rready_m), .sb_rdata_m(sb_rdata_m),
    .sb_wvalid_m(sb_wvalid_m), .sb_wready_m(sb_wready_m), .sb_waddr_m(sb_waddr_m),
    .sb_wdata_m(sb_wdata_m), .sb_wstrb_m(sb_wstrb_m),
    .sb_bvalid_m(sb_bvalid_m), .sb_bready_m(sb_bready_m), .sb_bresp_m(sb_bresp_m),
    .sb_arvalid_s(sb_arvalid_s), .sb_arready_s(sb_arready_s), .sb_araddr_s(sb_araddr_s),
    .sb_rvalid_s(sb_rvalid_s), .sb_rready_s(sb_rready_s), .sb_rdata_s(sb_rdata_s),
    .sb_wvalid_s(sb_wvalid_s), .sb_wready_s(sb_wready_s), .sb_waddr_s(sb_waddr_s),
    .sb_wdata_s(sb_wdata_s), .sb_wstrb_s(sb_wstrb_s),
    .sb_bvalid_s(sb_bvalid_s), .sb_bready_s(sb_bready_s), .sb_bresp_s(sb_bresp_s),
    .dec_err(dec_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] rq[$];
  logic        bq[$];

  // Master-side request state
  logic        run = 1'b0;
  logic        ar_active = 1'b0, w_active = 1'b0;
  logic [31:0] ar_addr = '0, w_addr = '0, w_data = '0;
  logic [3:0]  w_strb = '0;

  // Slave-side outstanding state
  logic        r_pend[4], b_pend[4];
  int          r_dly[4], b_dly[4];
  logic [31:0] r_addr[4], b_addr[4];

  // Memory map as address ranges
  function automatic int ref_sel(input logic [31:0] a);
    if (a[31:16] == 16'h0000)  return 0;
    if (a[31:16] == 16'h2000)  return 1;
    if (a[31:12] == 20'h40000) return 2;
    if (a[31:12] == 20'h40001) return 3;
    return 4;
  endfunction

  // Data a slave returns for a read of address a
  function automatic logic [31:0] sdata(input int i, input logic [31:0] a);
    logic [31:0] k;
    k = 32'(i + 1);
    return (32'h1111_1111 * k) ^ {a[15:0], a[31:16]};
  endfunction

  // Response a slave returns for a write of address a
  function automatic logic sresp(input int i, input logic [31:0] a);
    return a[3] ^ a[i];
  endfunction

  function automatic logic [31:0] gen_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {16'h0000, r[15:0]};
      1:       return {16'h2000, r[15:0]};
      2:       return {20'h40000, r[11:0]};
      3:       return {20'h40001, r[11:0]};
      4:       return r;
      default: return {20'h40002, r[11:0]};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: observe handshakes at negedge, advance models after posedge
  task automatic step();
    logic       arok, wok;
    logic [3:0] acc_ar, rdone, acc_w, bdone;
    int         s;
    @(negedge clk);
    arok = sb_arvalid_m & sb_arready_m;
    wok  = sb_wvalid_m & sb_wready_m;
    if (arok) begin
      s = ref_sel(ar_addr);
      rq.push_back(s == 4 ? ERR_RDATA : sdata(s, ar_addr));
    end
    if (wok) begin
      s = ref_sel(w_addr);
      bq.push_back(s == 4 ? 1'b1 : sresp(s, w_addr));
    end
    for (int i = 0; i < 4; i++) begin
      acc_ar[i] = sb_arvalid_s[i] & sb_arready_s[i];
      rdone[i]  = sb_rvalid_s[i] & sb_rready_s[i];
      acc_w[i]  = sb_wvalid_s[i] & sb_wready_s[i];
      bdone[i]  = sb_bvalid_s[i] & sb_bready_s[i];
      if (sb_arvalid_s[i]) begin
        check("arvalid_s target", 32'(ref_sel(ar_addr)), 32'(i));
        check("araddr_s broadcast", sb_araddr_s, ar_addr);
      end
      if (sb_wvalid_s[i]) begin
        check("wvalid_s target", 32'(ref_sel(w_addr)), 32'(i));
        check("waddr_s broadcast", sb_waddr_s, w_addr);
        check("wdata_s broadcast", sb_wdata_s, w_data);
        check("wstrb_s broadcast", 32'(sb_wstrb_s), 32'(w_strb));
      end
      if (sb_rready_s[i]) check("rready_s to idle slave", 32'(r_pend[i]), 32'd1);
      if (sb_bready_s[i]) check("bready_s to idle slave", 32'(b_pend[i]), 32'd1);
    end
    @(posedge clk);
    #1;
    if (arok) ar_active = 1'b0;
    if (wok)  w_active  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rdone[i]) r_pend[i] = 1'b0;
      if (acc_ar[i]) begin
        r_pend[i] = 1'b1;
        r_dly[i]  = $urandom_range(0, 3);
        r_addr[i] = ar_addr;
      end else if (r_pend[i] && r_dly[i] != 0) begin
        r_dly[i]--;
      end
      if (bdone[i]) b_pend[i] = 1'b0;
      if (acc_w[i]) begin
        b_pend[i] = 1'b1;
        b_dly[i]  = $urandom_range(0, 3);
        b_addr[i] = w_addr;
      end else if (b_pend[i] && b_dly[i] != 0) begin
        b_dly[i]--;
      end
    end
    if (run && !ar_active && $urandom_range(0, 2) == 0) begin
      ar_active = 1'b1;
      ar_addr   = gen_addr();
    end
    if (run && !w_active && $urandom_range(0, 2) == 0) begin
      w_active = 1'b1;
      w_addr   = gen_addr();
      w_data   = $urandom;
      w_strb   = 4'($urandom);
    end
    sb_arvalid_m = ar_active;
    sb_araddr_m  = ar_addr;
    sb_wvalid_m  = w_active;
    sb_waddr_m   = w_addr;
    sb_wdata_m   = w_data;
    sb_wstrb_m   = w_strb;
    sb_rready_m  = ($urandom_range(0, 3) != 0);
    sb_bready_m  = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) begin
      sb_arready_s[i] = 1'($urandom_range(0, 1));
      sb_wready_s[i]  = 1'($urandom_range(0, 1));
      if (r_pend[i] && r_dly[i] == 0) begin
        sb_rvalid_s[i]         = 1'b1;
        sb_rdata_s[32*i +: 32] = sdata(i, r_addr[i]);
      end else begin
        sb_rvalid_s[i]         = !r_pend[i] && ($urandom_range(0, 4) == 0);
        sb_rdata_s[32*i +: 32] = $urandom;
      end
      if (b_pend[i] && b_dly[i] == 0) begin
        sb_bvalid_s[i] = 1'b1;
        sb_bresp_s[i]  = sresp(i, b_addr[i]);
      end else begin
        sb_bvalid_s[i] = !b_pend[i] && ($urandom_range(0, 4) == 0);
        sb_bresp_s[i]  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Response monitor: compares every completed R/B against the scoreboard
  initial begin
    logic exp_dec;
    exp_dec = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_dec = 1'b0;
      end else begin
        if (exp_dec || dec_err) check("dec_err pulse", 32'(dec_err), 32'(exp_dec));
        if (sb_rvalid_m && sb_rready_m) begin
          if (rq.size() == 0) check("unexpected R", 32'd1, 32'd0);
          else                check("rdata_m", sb_rdata_m, rq.pop_front());
        end
        if (sb_bvalid_m && sb_bready_m) begin
          if (bq.size() == 0) check("unexpected B", 32'd1, 32'd0);
          else                check("bresp_m", 32'(sb_bresp_m), 32'(bq.pop_front()));
        end
        exp_dec = (sb_arvalid_m && sb_arready_m && ref_sel(sb_araddr_m) == 4) ||
                  (sb_wvalid_m && sb_wready_m && ref_sel(sb_waddr_m) == 4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic idle;
    for (int i = 0; i < 4; i++) begin
      r_pend[i] = 1'b0; b_pend[i] = 1'b0;
      r_dly[i]  = 0;    b_dly[i]  = 0;
      r_addr[i] = '0;   b_addr[i] = '0;
    end
    sb_arvalid_m = 1'b0; sb_araddr_m = '0; sb_rready_m = 1'b0;
    sb_wvalid_m  = 1'b0; sb_waddr_m  = '0; sb_wdata_m  = '0; sb_wstrb_m = '0;
    sb_bready_m  = 1'b0;
    sb_arready_s = '0; sb_rvalid_s = '0; sb_rdata_s = '0;
    sb_wready_s  = '0; sb_bvalid_s = '0; sb_bresp_s = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset arvalid_s", 32'(sb_arvalid_s), 32'd0);
    check("reset wvalid_s", 32'(sb_wvalid_s), 32'd0);
    check("reset rvalid_m", 32'(sb_rvalid_m), 32'd0);
    check("reset bvalid_m", 32'(sb_bvalid_m), 32'd0);
    check("reset dec_err", 32'(dec_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run = 1'b1;
    repeat (3000) step();
    run = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 300 && !idle; k++) begin
      step();
      idle = !ar_active && !w_active && rq.size() == 0 && bq.size() == 0;
    end
    check("drain completes", 32'(idle), 32'd1);

    // Reset in the middle of a stalled read to slave 0
    sb_rvalid_s = '0; sb_bvalid_s = '0; sb_wvalid_m = 1'b0; sb_wready_s = '0;
    sb_arready_s = 4'b0001; sb_rready_m = 1'b1;
    sb_arvalid_m = 1'b1; sb_araddr_m = 32'h0000_0040; ar_addr = 32'h0000_0040;
    @(negedge clk);
    check("stall AR arready_m", 32'(sb_arready_m), 32'd1);
    check("stall AR arvalid_s", 32'(sb_arvalid_s), 32'h1);
    @(posedge clk);
    #1 sb_arvalid_m = 1'b0; sb_arready_s = '0;
    @(negedge clk);
    check("stall rvalid_m", 32'(sb_rvalid_m), 32'd0);
    check("stall rready_s", 32'(sb_rready_s), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("async reset rready_s", 32'(sb_rready_s), 32'd0);
    check("async reset rvalid_m", 32'(sb_rvalid_m), 32'd0);
    check("async reset arvalid_s", 32'(sb_arvalid_s), 32'd0);
    check("async reset wvalid_s", 32'(sb_wvalid_s), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 sb_rvalid_s = 4'b0001; sb_rdata_s[31:0] = 32'hBAD0_0000;
    @(negedge clk);
    check("late response ignored rvalid_m", 32'(sb_rvalid_m), 32'd0);
    check("late response ignored rready_s", 32'(sb_rready_s), 32'd0);
    @(posedge clk);
    #1 sb_rvalid_s = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
